// File: rtl/window3x3_gen.sv
// window3x3_gen: streaming 3x3 neighbourhood generator.
//
// Takes a raster-order pixel stream and presents the nine pixels of every
// fully-interior 3x3 window, one clock after the pixel that completes it.
// Two line buffers supply the two previous lines at the current column.
// Pixels from the first two rows and first two columns of a frame produce
// no window.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sof        start of frame, qualified by pix_valid; marks pixel (0,0)
//   pix_in     input pixel, DATA_W bits
//   pix_valid  pix_in accepted this cycle (no backpressure)
//   p0..p2     window top row    (line r-2), columns c-2, c-1, c
//   p3..p5     window middle row (line r-1); p4 is the window centre
//   p6..p8     window bottom row (line r),   columns c-2, c-1, c
//   win_valid  p0..p8 hold a complete window this cycle
//   win_last   this window belongs to the last pixel of the frame
module window3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic              win_valid,
  output logic              win_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  // Line buffers are plain distributed RAM: never reset, since windows are
  // suppressed until two fresh lines have been written.
  logic [DATA_W-1:0] lb_a [IMG_WIDTH];  // line r-2
  logic [DATA_W-1:0] lb_b [IMG_WIDTH];  // line r-1
  logic [DATA_W-1:0] a_rd, b_rd;

  // win_q[3*k+j]: window row k (0 = oldest line), column j (0 = leftmost).
  logic [8:0][DATA_W-1:0] win_q;
  logic [2:0][DATA_W-1:0] col_in;       // new right-hand column, top first
  logic                   win_valid_q, win_last_q;

  // sof overrides the counters so a mid-frame restart takes effect on the
  // very pixel that carries it.
  assign cur_col = sof ? '0 : col_q;
  assign cur_row = sof ? '0 : row_q;

  assign a_rd   = lb_a[cur_col];
  assign b_rd   = lb_b[cur_col];
  assign col_in = {pix_in, b_rd, a_rd};

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      // Strobes are recomputed every cycle, so an idle cycle clears them.
      win_valid_q <= pix_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      win_last_q  <= pix_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (pix_valid) begin
        for (int k = 0; k < 3; k++) begin
          win_q[3*k]   <= win_q[3*k+1];
          win_q[3*k+1] <= win_q[3*k+2];
          win_q[3*k+2] <= col_in[k];
        end
      end
    end
  end

  // Each column slot ages one line per pass: r-1 moves to r-2, new pixel
  // becomes r-1.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_a[cur_col] <= b_rd;
      lb_b[cur_col] <= pix_in;
    end
  end

  assign p0 = win_q[0];
  assign p1 = win_q[1];
  assign p2 = win_q[2];
  assign p3 = win_q[3];
  assign p4 = win_q[4];
  assign p5 = win_q[5];
  assign p6 = win_q[6];
  assign p7 = win_q[7];
  assign p8 = win_q[8];

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

endmodule
